morse_stream_encoder: RTL and testbench

Parametrised, buffered Morse encoder: accepts 5-bit character codes over a valid/ready handshake into an internal FIFO and transmits them back-to-back as on/off keying with standard ITU timing. Unit length is configurable in clock cycles. Successor to the single-shot start-pulse encoder: characters can be queued while a transmission is in flight, and invalid codes are flagged. Sits between the user-input decode logic and the Morse output pin of the Tiny Tapeout top.

---
 rtl/morse_pkg.sv | 38 +++
 rtl/morse_fifo.sv | 37 +++
 rtl/morse_stream_encoder.sv | 117 +++++++++++
 tb/tb_morse_stream_encoder.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/morse_pkg.sv
// morse_pkg: FSM state codes, character code limits, gap lengths and the A..Z element lookup
package morse_pkg;
    localparam logic [2:0] S_IDLE = 3'd0, S_LOAD = 3'd1, S_MARK = 3'd2, S_GAP = 3'd3, S_CHAR_GAP = 3'd4, S_WORD_GAP = 3'd5;
    localparam logic [4:0] CODE_SPACE = 5'd0, CODE_MAX_VALID = 5'd26;
    localparam int GAP_ELEM_UNITS = 1, GAP_CHAR_UNITS = 3, GAP_WORD_UNITS = 4, DASH_UNITS = 3;
    // {length, pattern}: pattern is MSB-first, 1 = dash
    function automatic logic [6:0] morse_lookup(input logic [4:0] code);
        case (code)
            5'd1:  morse_lookup = {3'd2, 4'b0100};
            5'd2:  morse_lookup = {3'd4, 4'b1000};
            5'd3:  morse_lookup = {3'd4, 4'b1010};
            5'd4:  morse_lookup = {3'd3, 4'b1000};
            5'd5:  morse_lookup = {3'd1, 4'b0000};
            5'd6:  morse_lookup = {3'd4, 4'b0010};
            5'd7:  morse_lookup = {3'd3, 4'b1100};
            5'd8:  morse_lookup = {3'd4, 4'b0000};
            5'd9:  morse_lookup = {3'd2, 4'b0000};
            5'd10: morse_lookup = {3'd4, 4'b0111};
            5'd11: morse_lookup = {3'd3, 4'b1010};
            5'd12: morse_lookup = {3'd4, 4'b0100};
            5'd13: morse_lookup = {3'd2, 4'b1100};
            5'd14: morse_lookup = {3'd2, 4'b1000};
            5'd15: morse_lookup = {3'd3, 4'b1110};
            5'd16: morse_lookup = {3'd4, 4'b0110};
            5'd17: morse_lookup = {3'd4, 4'b1101};
            5'd18: morse_lookup = {3'd3, 4'b0100};
            5'd19: morse_lookup = {3'd3, 4'b0000};
            5'd20: morse_lookup = {3'd1, 4'b1000};
            5'd21: morse_lookup = {3'd3, 4'b0010};
            5'd22: morse_lookup = {3'd4, 4'b0001};
            5'd23: morse_lookup = {3'd3, 4'b0110};
            5'd24: morse_lookup = {3'd4, 4'b1001};
            5'd25: morse_lookup = {3'd4, 4'b1011};
            5'd26: morse_lookup = {3'd4, 4'b1100};
            default: morse_lookup = 7'd0;
        endcase
    endfunction
endpackage

// File: rtl/morse_fifo.sv
// morse_fifo: synchronous FIFO with wrap-bit pointers; reset flushes the queue
module morse_fifo #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0] wr_q, wr_d, rd_q, rd_d;
    assign full = wr_q == {~rd_q[AW], rd_q[AW-1:0]};
    assign empty = wr_q == rd_q;
    assign dout = mem_q[rd_q[AW-1:0]];
    always_comb begin
        wr_d = push && !full ? wr_q + 1'b1 : wr_q;
        rd_d = pop && !empty ? rd_q + 1'b1 : rd_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end
    always_ff @(posedge clk) begin
        if (push && !full) mem_q[wr_q[AW-1:0]] <= din;
    end
endmodule

// File: rtl/morse_stream_encoder.sv
// morse_stream_encoder: buffered A..Z Morse keyer with ITU timing; define MORSE_TONE_EN for a keyed sidetone on tone_out
module morse_stream_encoder
    import morse_pkg::*;
#(
    parameter int UNIT_CYCLES = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int TONE_DIV = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [4:0] in_code,
    output logic       morse_out,
    output logic       busy,
    output logic       err,
    output logic       tone_out
);
    localparam int CW = $clog2(UNIT_CYCLES * 3);
    localparam logic [CW-1:0] U_LAST = CW'(UNIT_CYCLES - 1);
    logic [2:0] state_q, state_d, len_q, len_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0] units_q, units_d, start_units;
    logic [4:0] code_q, code_d, fifo_dout, start_code;
    logic [3:0] pat_q, pat_d, start_pat;
    logic [6:0] look;
    logic err_q, err_d, fifo_full, fifo_empty, fifo_push, fifo_pop, unit_end, gap_end;
    morse_fifo #(.WIDTH(5), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk),
        .rst(rst),
        .push(fifo_push),
        .pop(fifo_pop),
        .din(in_code),
        .dout(fifo_dout),
        .full(fifo_full),
        .empty(fifo_empty)
    );
    assign in_ready = !fifo_full;
    assign fifo_push = in_valid && in_ready && in_code <= CODE_MAX_VALID;
    assign err_d = in_valid && in_ready && in_code > CODE_MAX_VALID;
    assign unit_end = cnt_q == '0 && units_q == '0;
    assign gap_end = unit_end && (state_q == S_CHAR_GAP || state_q == S_WORD_GAP);
    assign fifo_pop = !fifo_empty && (state_q == S_IDLE || gap_end);
    assign look = morse_lookup(fifo_dout);
    // LOAD starts from the registered pop; a gap ending with data waiting starts straight from the FIFO head
    assign start_code = state_q == S_LOAD ? code_q : fifo_dout;
    assign start_pat = state_q == S_LOAD ? pat_q : look[3:0];
    assign start_units = start_code == CODE_SPACE ? 2'(GAP_WORD_UNITS - 1) : start_pat[3] ? 2'(DASH_UNITS - 1) : 2'd0;
    assign morse_out = state_q == S_MARK;
    assign busy = state_q != S_IDLE || !fifo_empty;
    assign err = err_q;
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q == '0 ? U_LAST : cnt_q - 1'b1;
        units_d = cnt_q == '0 ? units_q - 2'd1 : units_q;
        code_d = fifo_pop ? fifo_dout : code_q;
        len_d = fifo_pop ? look[6:4] : len_q;
        pat_d = fifo_pop ? look[3:0] : pat_q;
        if (state_q == S_IDLE) begin
            state_d = fifo_pop ? S_LOAD : S_IDLE;
        end else if (state_q == S_LOAD || (gap_end && fifo_pop)) begin
            state_d = start_code == CODE_SPACE ? S_WORD_GAP : S_MARK;
            cnt_d = U_LAST;
            units_d = start_units;
        end else if (unit_end && state_q == S_MARK) begin
            state_d = len_q > 3'd1 ? S_GAP : S_CHAR_GAP;
            units_d = len_q > 3'd1 ? 2'(GAP_ELEM_UNITS - 1) : 2'(GAP_CHAR_UNITS - 1);
            len_d = len_q - 3'd1;
            pat_d = pat_q << 1;
        end else if (unit_end && state_q == S_GAP) begin
            state_d = S_MARK;
            units_d = pat_q[3] ? 2'(DASH_UNITS - 1) : 2'd0;
        end else if (gap_end) begin
            state_d = S_IDLE;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q <= '0;
            units_q <= '0;
            code_q <= '0;
            len_q <= '0;
            pat_q <= '0;
            err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            units_q <= units_d;
            code_q <= code_d;
            len_q <= len_d;
            pat_q <= pat_d;
            err_q <= err_d;
        end
    end
`ifdef MORSE_TONE_EN
    localparam int TW = $clog2(TONE_DIV + 1);
    logic [TW-1:0] div_q, div_d;
    logic tone_q, tone_d;
    always_comb begin
        div_d = morse_out && div_q != TW'(TONE_DIV - 1) ? div_q + 1'b1 : '0;
        tone_d = morse_out && (div_q == TW'(TONE_DIV - 1) ? !tone_q : tone_q);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q <= '0;
            tone_q <= 1'b0;
        end else begin
            div_q <= div_d;
            tone_q <= tone_d;
        end
    end
    assign tone_out = tone_q && morse_out;
`else
    assign tone_out = 1'b0;
`endif
endmodule

// File: tb/tb_morse_stream_encoder.sv
// tb_morse_stream_encoder: scoreboard bench comparing keyed mark/gap runs against a Morse-string reference model
module tb_morse_stream_encoder;
    localparam int U = 4, DEPTH = 4;
    logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0;
    logic [4:0] in_code = 5'd0;
    logic in_ready, morse_out, busy, err, tone_out;
    int n_cmp = 0, n_bad = 0, cyc = 0;
    typedef struct {int mark; int gap; bit exact;} elem_t;
    elem_t exp_q[$];
    elem_t e_mon;
    int err_q[$];
    int nsp = 0, run = 0, gap = 0;
    bit prev_char = 0, hi = 0;
    string tab [27] = '{"", ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---", "-.-", ".-..",
                        "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-", "..-", "...-", ".--", "-..-", "-.--", "--.."};
    morse_stream_encoder #(.UNIT_CYCLES(U), .FIFO_DEPTH(DEPTH), .TONE_DIV(8)) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_code(in_code),
        .morse_out(morse_out),
        .busy(busy),
        .err(err),
        .tone_out(tone_out)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask
    task automatic check_ge(input string name, input int act, input int min);
        n_cmp++;
        if (act < min) begin
            n_bad++;
            $display("FAIL %s: got %0d expected at least %0d (cycle %0d)", name, act, min, cyc);
        end
    endtask
    // Reference: each letter expands to its dot/dash string; gaps follow ITU unit counts
    task automatic model_accept(input logic [4:0] code);
        int idx;
        bit queued;
        elem_t e;
        idx = int'(code);
        queued = exp_q.size() != 0;
        if (idx > 26) err_q.push_back(cyc + 1);
        else if (idx == 0) nsp++;
        else begin
            for (int i = 0; i < tab[idx].len(); i++) begin
                e.mark = tab[idx][i] == "-" ? 3 * U : U;
                e.gap = i > 0 ? U : (prev_char ? 3 * U : 0) + 4 * U * nsp;
                e.exact = i > 0 || queued;
                exp_q.push_back(e);
            end
            prev_char = 1;
            nsp = 0;
        end
    endtask
    task automatic send(input logic [4:0] code);
        int w;
        w = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_code = code;
        while (!in_ready && w < 500) begin
            @(negedge clk);
            w++;
        end
        if (in_ready) model_accept(code);
        else check("in_ready timeout", int'(in_ready), 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask
    task automatic timed(input logic [4:0] code, input int rise_exp, input int idle_exp, input string nm);
        int ck, rise, idle;
        rise = -1;
        idle = -1;
        send(code);
        ck = cyc;
        for (int i = 0; i < 200 && idle < 0; i++) begin
            @(negedge clk);
            if (morse_out && rise < 0) rise = cyc - ck;
            if (!busy && idle < 0) idle = cyc - ck;
        end
        check({nm, " first key-down"}, rise, rise_exp);
        check({nm, " busy fall"}, idle, idle_exp);
    endtask
    task automatic drain(input string nm);
        int w;
        w = 0;
        while ((busy || exp_q.size() != 0) && w < 5000) begin
            @(negedge clk);
            w++;
        end
        check({nm, " pending marks"}, exp_q.size(), 0);
        check({nm, " busy"}, int'(busy), 0);
    endtask
    always @(negedge clk) begin
        if (rst) begin
            hi = 0;
            run = 0;
        end else begin
            check("err", int'(err), int'(err_q.size() != 0 && err_q[0] == cyc));
            if (err_q.size() != 0 && err_q[0] <= cyc) void'(err_q.pop_front());
`ifdef MORSE_TONE_EN
            if (tone_out) check("tone while key up", int'(morse_out), 1);
`else
            check("tone_out", int'(tone_out), 0);
`endif
            if (morse_out == hi) run++;
            else begin
                if (hi) begin
                    if (exp_q.size() == 0) check("unexpected mark", run, 0);
                    else begin
                        e_mon = exp_q.pop_front();
                        check("mark length", run, e_mon.mark);
                        if (e_mon.exact) check("gap length", gap, e_mon.gap);
                        else check_ge("gap length", gap, e_mon.gap);
                    end
                end else gap = run;
                hi = morse_out;
                run = 1;
            end
        end
    end
    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
    initial begin
        int r, w;
        logic [4:0] c;
        repeat (3) @(negedge clk);
        check("reset in_ready", int'(in_ready), 1);
        check("reset morse_out", int'(morse_out), 0);
        check("reset busy", int'(busy), 0);
        check("reset err", int'(err), 0);
        check("reset tone_out", int'(tone_out), 0);
        rst = 1'b0;
        timed(5'd5, 2, 18, "E");
        timed(5'd1, 2, 34, "A");
        send(5'd8);
        send(5'd9);
        drain("HI");
        send(5'd30);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("invalid busy", int'(busy), 0);
            check("invalid morse_out", int'(morse_out), 0);
        end
        send(5'd1);
        for (int i = 0; i < DEPTH; i++) send(5'(i + 2));
        @(negedge clk);
        check("in_ready when full", int'(in_ready), 0);
        send(5'd20);
        drain("full");
        send(5'd20);
        send(5'd5);
        send(5'd1);
        w = 0;
        while (!morse_out && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("dash started", int'(morse_out), 1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        err_q.delete();
        nsp = 0;
        prev_char = 0;
        @(negedge clk);
        check("mid reset morse_out", int'(morse_out), 0);
        check("mid reset busy", int'(busy), 0);
        check("mid reset err", int'(err), 0);
        check("mid reset tone_out", int'(tone_out), 0);
        check("mid reset in_ready", int'(in_ready), 1);
        @(negedge clk);
        rst = 1'b0;
        timed(5'd5, 2, 18, "E after reset");
        for (int n = 0; n < 40; n++) begin
            r = int'($urandom_range(0, 9));
            c = r == 0 ? 5'd0 : r == 1 ? 5'($urandom_range(27, 31)) : 5'($urandom_range(1, 26));
            send(c);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 60)) @(negedge clk);
        end
        drain("random");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
